// File: rtl/bus_arbiter_if.sv
// Datapath bus arbitration signals: driver requests/locks in, one-hot grant and cc-load out.
interface bus_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] lock;
    logic [NREQ-1:0] cc_upd;
    logic            err_clr;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            bus_en;
    logic            ld_cc;
    logic            lock_err;

    modport master (
        output req, lock, cc_upd, err_clr,
        input  gnt, gnt_idx, bus_en, ld_cc, lock_err
    );

    modport slave (
        input  req, lock, cc_upd, err_clr,
        output gnt, gnt_idx, bus_en, ld_cc, lock_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// Single-owner datapath bus arbiter (round-robin or fixed priority) with bounded lock and watchdog.
// Grant one cycle after request; lock holds the owner up to MAX_LOCK cycles; ld_cc is one AND past the registers.
module bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_LOCK = 15,
    parameter bit RR       = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_arbiter_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_LOCKED
    } state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [IW-1:0]   r_gnt_idx;
    logic [IW-1:0]   r_ptr;
    logic            r_bus_en;
    logic            r_lock_err;
    logic [7:0]      r_hold_cnt;

    logic            w_owner_lock;
    logic            w_hold;
    logic            w_wdog;
    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_idx;

    // Only the current owner's lock bit matters; everyone else's is ignored.
    assign w_owner_lock = (r_state != S_IDLE) && bus.lock[r_gnt_idx];
    assign w_hold       = w_owner_lock && (r_hold_cnt < 8'(MAX_LOCK));
    assign w_wdog       = w_owner_lock && !w_hold;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (RR) w_idx = IW'((int'(r_ptr) + k) % NREQ);
            else    w_idx = IW'(k);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_ptr      <= '0;
            r_bus_en   <= 1'b0;
            r_lock_err <= 1'b0;
            r_hold_cnt <= 8'd0;
        end else begin
            if (w_wdog)            r_lock_err <= 1'b1;
            else if (bus.err_clr)  r_lock_err <= 1'b0;

            if (w_hold) begin
                r_state    <= S_LOCKED;
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end else if (w_found) begin
                r_state    <= S_GRANT;
                r_gnt      <= NREQ'(1) << w_win;
                r_gnt_idx  <= w_win;
                r_bus_en   <= 1'b1;
                r_hold_cnt <= 8'd1;
                if (RR) r_ptr <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + IW'(1);
            end else begin
                r_state    <= S_IDLE;
                r_gnt      <= '0;
                r_gnt_idx  <= '0;
                r_bus_en   <= 1'b0;
                r_hold_cnt <= 8'd0;
            end
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.gnt_idx  = r_gnt_idx;
    assign bus.bus_en   = r_bus_en;
    assign bus.lock_err = r_lock_err;
    // Same-cycle cc_upd so the NZP register captures the bus at the end of this cycle.
    assign bus.ld_cc    = r_bus_en & bus.cc_upd[r_gnt_idx];
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a round-robin instance and a fixed-priority instance side by side.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NREQ(4)) ia ();
    bus_arbiter_if #(.NREQ(4)) ib ();

    bus_arbiter #(.NREQ(4), .MAX_LOCK(15), .RR(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    bus_arbiter #(.NREQ(4), .MAX_LOCK(15), .RR(1'b0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       bus_en;
        logic       ld_cc;
        logic       lock_err;
    } obs_t;

    obs_t exp_q[$];
    obs_t got, e;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic obs_t obs_a();
        return {ia.gnt, ia.gnt_idx, ia.bus_en, ia.ld_cc, ia.lock_err};
    endfunction

    function automatic obs_t obs_b();
        return {ib.gnt, ib.gnt_idx, ib.bus_en, ib.ld_cc, ib.lock_err};
    endfunction

    function automatic obs_t mk(input logic [3:0] g, input logic [1:0] i, input logic ld, input logic le);
        return {g, i, (g != 4'b0000), ld, le};
    endfunction

    task automatic drive_a(input logic [3:0] r, input logic [3:0] l, input logic [3:0] c, input logic ec);
        ia.req = r; ia.lock = l; ia.cc_upd = c; ia.err_clr = ec;
    endtask

    task automatic drive_b(input logic [3:0] r, input logic [3:0] l, input logic [3:0] c, input logic ec);
        ib.req = r; ib.lock = l; ib.cc_upd = c; ib.err_clr = ec;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        drive_a(4'b0, 4'b0, 4'b0, 1'b0);
        drive_b(4'b0, 4'b0, 4'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_a(4'b1111, 4'b1111, 4'b1111, 1'b0);
        drive_b(4'b1111, 4'b1111, 4'b1111, 1'b0);
        exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        step();
        got = obs_a(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL reset_rr: got %b expected %b", got, e); end
        got = obs_b(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL reset_fp: got %b expected %b", got, e); end
        reset_all();
    endtask

    task automatic test_single();
        reset_all();
        drive_a(4'b0010, 4'b0000, 4'b0010, 1'b0);
        exp_q.push_back(mk(4'b0010, 2'd1, 1'b1, 1'b0));
        step();
        got = obs_a(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL single_gnt: got %b expected %b", got, e); end
        drive_a(4'b0000, 4'b0000, 4'b0010, 1'b0);
        exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        step();
        got = obs_a(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL single_release: got %b expected %b", got, e); end
    endtask

    task automatic test_round_robin();
        logic [3:0] cc;
        cc = 4'b0101;
        reset_all();
        drive_a(4'b1111, 4'b0000, cc, 1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(4'b0001 << (i % 4), 2'(i % 4), cc[i % 4], 1'b0));
            step();
            got = obs_a(); e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL rr_seq[%0d]: got %b expected %b", i, got, e); end
        end
    endtask

    task automatic test_fixed_priority();
        reset_all();
        drive_b(4'b1010, 4'b0000, 4'b1000, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) ib.req = 4'b1000;
            if (i < 6) exp_q.push_back(mk(4'b0010, 2'd1, 1'b0, 1'b0));
            else       exp_q.push_back(mk(4'b1000, 2'd3, 1'b1, 1'b0));
            step();
            got = obs_b(); e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL fp_seq[%0d]: got %b expected %b", i, got, e); end
        end
    endtask

    task automatic test_lock_hold();
        reset_all();
        for (int i = 0; i < 6; i++) begin
            drive_a((i == 0) ? 4'b0100 : 4'b0101, (i < 5) ? 4'b0100 : 4'b0000, 4'b0000, 1'b0);
            if (i < 5) exp_q.push_back(mk(4'b0100, 2'd2, 1'b0, 1'b0));
            else       exp_q.push_back(mk(4'b0001, 2'd0, 1'b0, 1'b0));
            step();
            got = obs_a(); e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL lock_hold[%0d]: got %b expected %b", i, got, e); end
        end
    endtask

    task automatic test_fp_watchdog();
        reset_all();
        drive_b(4'b0001, 4'b0001, 4'b0000, 1'b0);
        for (int i = 0; i < 17; i++) begin
            exp_q.push_back(mk(4'b0001, 2'd0, 1'b0, (i >= 15)));
            step();
            got = obs_b(); e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL fp_wdog[%0d]: got %b expected %b", i, got, e); end
        end
    endtask

    task automatic test_watchdog();
        reset_all();
        for (int i = 0; i < 18; i++) begin
            drive_a((i == 0) ? 4'b1000 : 4'b0000, 4'b1000, 4'b1000, (i == 17));
            if (i < 15)      exp_q.push_back(mk(4'b1000, 2'd3, 1'b1, 1'b0));
            else if (i < 17) exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b1));
            else             exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
            step();
            got = obs_a(); e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL wdog[%0d]: got %b expected %b", i, got, e); end
        end
        // err_clr held high across the expiry edge: the set must win there.
        for (int i = 0; i < 16; i++) begin
            drive_a((i == 0) ? 4'b1000 : 4'b0000, 4'b1000, 4'b1000, 1'b1);
            if (i < 15) exp_q.push_back(mk(4'b1000, 2'd3, 1'b1, 1'b0));
            else        exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b1));
            step();
            got = obs_a(); e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL wdog_setclr[%0d]: got %b expected %b", i, got, e); end
        end
        ia.err_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        drive_a(4'b0010, 4'b0010, 4'b0010, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(4'b0010, 2'd1, 1'b1, 1'b1));
            step();
            got = obs_a(); e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_err++; $display("FAIL pre_reset_lock[%0d]: got %b expected %b", i, got, e); end
        end
        #2 rst_n = 1'b0;
        exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        #1;
        got = obs_a(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL async_reset: got %b expected %b", got, e); end
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(4'b1001, 4'b0000, 4'b0000, 1'b0);
        exp_q.push_back(mk(4'b0001, 2'd0, 1'b0, 1'b0));
        step();
        got = obs_a(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL ptr_restart: got %b expected %b", got, e); end
        drive_a(4'b1000, 4'b0000, 4'b0000, 1'b0);
        exp_q.push_back(mk(4'b1000, 2'd3, 1'b0, 1'b0));
        step();
        got = obs_a(); e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_err++; $display("FAIL post_reset_gnt: got %b expected %b", got, e); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        drive_a(4'b0, 4'b0, 4'b0, 1'b0);
        drive_b(4'b0, 4'b0, 4'b0, 1'b0);
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_priority();
        test_lock_hold();
        test_fp_watchdog();
        test_watchdog();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
